// File: rtl/ecc_seq_pkg.sv
// ----------------------------------------------------------------------------
// ecc_seq_pkg
// Shared types for the P-256 point-multiplier run sequencer.
//   state_e   : sequencer FSM states
//   ERR_*     : err_o codes reported to the register block
// ----------------------------------------------------------------------------
package ecc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ACK,
        S_RUN,
        S_CHECK,
        S_FAULT,
        S_DONE
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_ACK   = 2'd1;
    localparam logic [1:0] ERR_WDOG  = 2'd2;
    localparam logic [1:0] ERR_WORDS = 2'd3;

endpackage

// File: rtl/ecc_pmul_sequencer_if.sv
// ----------------------------------------------------------------------------
// ecc_pmul_sequencer_if
// Sequencer <-> curve_mul_256 core control bundle.
//   core_ena_o     : 1-cycle launch pulse (sequencer -> core)
//   core_rst_n_o   : core soft reset, active low (sequencer -> core)
//   core_rdy_i     : core idle / result ready (core -> sequencer)
//   core_rx_wren_i : Rx result-word write strobe (core -> sequencer)
//   core_ry_wren_i : Ry result-word write strobe (core -> sequencer)
// Signal names carry the sequencer's point of view.
// ----------------------------------------------------------------------------
interface ecc_pmul_sequencer_if;

    logic core_ena_o;
    logic core_rst_n_o;
    logic core_rdy_i;
    logic core_rx_wren_i;
    logic core_ry_wren_i;

    modport master (
        output core_ena_o, core_rst_n_o,
        input  core_rdy_i, core_rx_wren_i, core_ry_wren_i
    );

    modport slave (
        input  core_ena_o, core_rst_n_o,
        output core_rdy_i, core_rx_wren_i, core_ry_wren_i
    );

endinterface

// File: rtl/ecc_seq_run_meter.sv
// ----------------------------------------------------------------------------
// ecc_seq_run_meter
// Per-run measurement: saturating cycle counter with watchdog compare and
// Rx/Ry result-word strobe counters (saturating at pWORDS+1).
//   clk, rst_n : clock, async active-low reset
//   clr        : zero all counters
//   en         : count cycles / strobes this cycle
//   rx_wren    : Rx word strobe
//   ry_wren    : Ry word strobe
//   timeout    : watchdog limit, 0 disables
//   cnt        : cycles counted so far in this run
//   words_ok   : both word counts equal pWORDS
//   expired    : this enabled cycle brings the count to the limit
// ----------------------------------------------------------------------------
module ecc_seq_run_meter #(
    parameter int pWORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        rx_wren,
    input  logic        ry_wren,
    input  logic [31:0] timeout,
    output logic [31:0] cnt,
    output logic        words_ok,
    output logic        expired
);

    localparam int              WC_W   = $clog2(pWORDS + 2);
    localparam logic [WC_W-1:0] WC_SAT = WC_W'(pWORDS + 1);
    localparam logic [WC_W-1:0] WC_EXP = WC_W'(pWORDS);

    logic [1:0]            wren;
    logic [1:0][WC_W-1:0]  wc_q;
    logic [31:0]           cnt_nxt;

    assign wren    = {ry_wren, rx_wren};
    assign cnt_nxt = (cnt == '1) ? cnt : cnt + 32'd1;

    // Evaluated on the incremented value so a run whose rdy lands on the
    // limit cycle reports cycles == timeout; the FSM lets rdy win that tie.
    assign expired  = en && (timeout != '0) && (cnt_nxt >= timeout);
    assign words_ok = (wc_q[0] == WC_EXP) && (wc_q[1] == WC_EXP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wc_q <= '0;
        end else if (clr) begin
            cnt  <= '0;
            wc_q <= '0;
        end else if (en) begin
            cnt <= cnt_nxt;
            for (int i = 0; i < 2; i++)
                if (wren[i] && wc_q[i] != WC_SAT)
                    wc_q[i] <= wc_q[i] + 1'b1;
        end
    end

endmodule

// File: rtl/ecc_pmul_sequencer.sv
// ----------------------------------------------------------------------------
// ecc_pmul_sequencer
// Run controller for the P-256 point multiplier. Launches 1..N back-to-back
// scalar multiplications per start, gates the capture trigger to one run,
// measures ena-to-rdy latency, and soft-resets the core on ack timeout,
// watchdog expiry, short result-word count or abort.
//   clk, rst_n   : crypt clock, async active-low reset
//   start_i      : 1-cycle start (taken only in IDLE)
//   abort_i      : cancel current command
//   repeat_i     : runs per command (0 -> 1), sampled at start
//   trig_run_i   : run index driving trigger_o, sampled at start
//   timeout_i    : per-run watchdog limit (0 = off), sampled at start
//   core         : core control bundle (master side)
//   trigger_o    : high from selected run's ena until its rdy returns
//   busy_o       : not IDLE
//   done_o       : 1-cycle completion pulse (success or error)
//   runs_done_o  : completed runs in current/last command
//   cycles_o     : latency of last completed run (saturating)
//   err_o        : error code, sticky until next start
// ----------------------------------------------------------------------------
module ecc_pmul_sequencer
    import ecc_seq_pkg::*;
#(
    parameter int pREP_W   = 8,
    parameter int pWORDS   = 8,
    parameter int pACK_MAX = 4,
    parameter int pRST_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [pREP_W-1:0]    repeat_i,
    input  logic [pREP_W-1:0]    trig_run_i,
    input  logic [31:0]          timeout_i,
    ecc_pmul_sequencer_if.master core,
    output logic                 trigger_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [pREP_W-1:0]    runs_done_o,
    output logic [31:0]          cycles_o,
    output logic [1:0]           err_o
);

    localparam int              AUX_MAX  = (pACK_MAX > pRST_CYC) ? pACK_MAX : pRST_CYC;
    localparam int              AUX_W    = $clog2(AUX_MAX + 1);
    localparam logic [AUX_W-1:0] ACK_LAST = AUX_W'(pACK_MAX - 1);
    localparam logic [AUX_W-1:0] RST_LAST = AUX_W'(pRST_CYC - 1);

    state_e              state_q, state_d;
    logic [pREP_W-1:0]   rep_q, trun_q, runs_d, eff_rep, trun_sel;
    logic [31:0]         to_q, run_cnt;
    logic [AUX_W-1:0]    aux_q;
    logic [1:0]          err_d;
    logic                trig_d, words_ok, expired, abort_hit;
    logic                ena_q, crst_n_q;

    assign eff_rep   = (rep_q == '0) ? pREP_W'(1) : rep_q;
    // Abort is ignored once the command is already winding down (FAULT/DONE).
    assign abort_hit = abort_i && (state_q inside {S_LAUNCH, S_ACK, S_RUN, S_CHECK});

    assign core.core_ena_o   = ena_q;
    assign core.core_rst_n_o = crst_n_q;

    ecc_seq_run_meter #(.pWORDS(pWORDS)) u_meter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_q == S_IDLE || state_q == S_LAUNCH),
        .en       (state_q == S_RUN),
        .rx_wren  (core.core_rx_wren_i),
        .ry_wren  (core.core_ry_wren_i),
        .timeout  (to_q),
        .cnt      (run_cnt),
        .words_ok (words_ok),
        .expired  (expired)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_o;
        runs_d   = runs_done_o;
        trig_d   = trigger_o;
        trun_sel = trun_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d  = S_LAUNCH;
                err_d    = ERR_NONE;
                runs_d   = '0;
                trun_sel = trig_run_i;
            end
            S_LAUNCH: state_d = S_ACK;
            S_ACK: begin
                if (!core.core_rdy_i) state_d = S_RUN;
                else if (aux_q == ACK_LAST) begin
                    state_d = S_FAULT;
                    err_d   = ERR_ACK;
                end
            end
            S_RUN: begin
                if (core.core_rdy_i) state_d = S_CHECK;
                else if (expired) begin
                    state_d = S_FAULT;
                    err_d   = ERR_WDOG;
                end
            end
            S_CHECK: begin
                if (!words_ok) begin
                    state_d = S_FAULT;
                    err_d   = ERR_WORDS;
                end else begin
                    runs_d  = runs_done_o + 1'b1;
                    state_d = (runs_d == eff_rep) ? S_DONE : S_LAUNCH;
                end
            end
            S_FAULT: if (aux_q == RST_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort_hit) begin
            state_d = S_FAULT;
            err_d   = err_o;
            runs_d  = runs_done_o;
        end

        // runs_d is the index of the run about to launch.
        if (state_d == S_LAUNCH)                      trig_d = (runs_d == trun_sel);
        else if (state_d inside {S_CHECK, S_FAULT})   trig_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            err_o       <= ERR_NONE;
            runs_done_o <= '0;
            trigger_o   <= 1'b0;
            aux_q       <= '0;
            ena_q       <= 1'b0;
            crst_n_q    <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            cycles_o    <= '0;
            rep_q       <= '0;
            trun_q      <= '0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            err_o       <= err_d;
            runs_done_o <= runs_d;
            trigger_o   <= trig_d;
            // Dwell counter shared by ACK and FAULT; restarts on every state change.
            aux_q       <= (state_d != state_q) ? '0 : aux_q + 1'b1;
            ena_q       <= (state_d == S_LAUNCH);
            crst_n_q    <= (state_d != S_FAULT);
            busy_o      <= (state_d != S_IDLE);
            done_o      <= (state_d == S_DONE);
            if (state_q == S_IDLE && start_i) begin
                rep_q  <= repeat_i;
                trun_q <= trig_run_i;
                to_q   <= timeout_i;
            end
            if (state_q == S_CHECK && !abort_hit)
                cycles_o <= run_cnt;
        end
    end

endmodule

// File: tb/tb_ecc_pmul_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ecc_pmul_sequencer
// Directed bench with a behavioural curve_mul_256 model. Each command pushes
// its expected completion record; a monitor pops and compares on done_o.
// ----------------------------------------------------------------------------
module tb_ecc_pmul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [7:0]  repeat_i = '0;
    logic [7:0]  trig_run_i = '0;
    logic [31:0] timeout_i = '0;
    logic        trigger_o, busy_o, done_o;
    logic [7:0]  runs_done_o;
    logic [31:0] cycles_o;
    logic [1:0]  err_o;

    ecc_pmul_sequencer_if core_if();

    ecc_pmul_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .repeat_i    (repeat_i),
        .trig_run_i  (trig_run_i),
        .timeout_i   (timeout_i),
        .core        (core_if),
        .trigger_o   (trigger_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .runs_done_o (runs_done_o),
        .cycles_o    (cycles_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int err, runs, cycles, enas, tidx, tcyc, rstl;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   n_chk = 0, n_fail = 0, ena_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(int err, int runs, int cyc, int enas, int tidx, int tcyc, int rstl);
        exp_t e;
        e.err = err; e.runs = runs; e.cycles = cyc; e.enas = enas;
        e.tidx = tidx; e.tcyc = tcyc; e.rstl = rstl;
        return e;
    endfunction

    // Core model: rdy drops the cycle after ena, result words are strobed
    // from the second busy cycle, rdy returns so that the sequencer counts
    // exactly m_lat RUN cycles.
    int m_lat = 100, m_rx = 8, m_ry = 8, m_cnt = 0;
    bit m_stuck = 0, m_busy = 0;

    always @(negedge clk) begin
        if (!rst_n || !core_if.core_rst_n_o) begin
            core_if.core_rdy_i     = 1'b1;
            core_if.core_rx_wren_i = 1'b0;
            core_if.core_ry_wren_i = 1'b0;
            m_busy = 0;
        end else if (core_if.core_ena_o && !m_stuck) begin
            m_busy = 1; m_cnt = 0;
            core_if.core_rdy_i     = 1'b0;
            core_if.core_rx_wren_i = 1'b0;
            core_if.core_ry_wren_i = 1'b0;
        end else if (m_busy) begin
            m_cnt++;
            core_if.core_rx_wren_i = (m_cnt >= 2 && m_cnt <= m_rx + 1);
            core_if.core_ry_wren_i = (m_cnt >= 2 && m_cnt <= m_ry + 1);
            if (m_cnt == m_lat + 1) begin
                core_if.core_rdy_i = 1'b1;
                m_busy = 0;
            end
        end
    end

    // Monitor: accumulates per-command observations, checks on done_o.
    int o_enas = 0, o_tidx = -1, o_tcyc = 0, o_rstl = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_if.core_ena_o) begin
                if (trigger_o) o_tidx = o_enas;
                o_enas++;
                ena_total++;
            end
            if (trigger_o) o_tcyc++;
            if (!core_if.core_rst_n_o) o_rstl++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    me = sb.pop_front();
                    chk("err_o",       err_o,       me.err);
                    chk("runs_done_o", runs_done_o, me.runs);
                    chk("cycles_o",    cycles_o,    me.cycles);
                    chk("ena_pulses",  o_enas,      me.enas);
                    chk("trig_run",    o_tidx,      me.tidx);
                    chk("trig_cycles", o_tcyc,      me.tcyc);
                    chk("core_rst_lo", o_rstl,      me.rstl);
                end
                o_enas = 0; o_tidx = -1; o_tcyc = 0; o_rstl = 0;
            end
        end
    end

    task automatic run_cmd(input int rep, input int trun, input int to, input exp_t e, input bit with_abort);
        repeat_i   = rep[7:0];
        trig_run_i = trun[7:0];
        timeout_i  = to;
        sb.push_back(e);
        @(negedge clk);
        start_i = 1'b1; abort_i = with_abort;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, busy_o, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int n;
        repeat (2) @(negedge clk);
        chk("rst_busy",    busy_o,               0);
        chk("rst_done",    done_o,               0);
        chk("rst_trigger", trigger_o,            0);
        chk("rst_ena",     core_if.core_ena_o,   0);
        chk("rst_core_rn", core_if.core_rst_n_o, 1);
        chk("rst_runs",    runs_done_o,          0);
        chk("rst_cycles",  cycles_o,             0);
        chk("rst_err",     err_o,                0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single run; trig_run == repeat so trigger stays low
        run_cmd(1, 1, 0, mk(0, 1, 100, 1, -1, 0, 0), 0);
        wait_idle("t1");

        // three runs, trigger only across run 1
        run_cmd(3, 1, 0, mk(0, 3, 100, 3, 1, 102, 0), 0);
        wait_idle("t2");

        // watchdog: limit 50, core needs 200
        m_lat = 200;
        run_cmd(1, 0, 50, mk(2, 0, 100, 1, 0, 52, 2), 0);
        wait_idle("t3");
        chk("err_sticky", err_o, 2);

        // ack timeout: rdy never drops
        m_stuck = 1;
        run_cmd(1, 9, 0, mk(1, 0, 100, 1, -1, 0, 2), 0);
        wait_idle("t4");
        m_stuck = 0;

        // short Rx word count
        m_lat = 60; m_rx = 7;
        run_cmd(2, 5, 0, mk(3, 0, 60, 1, -1, 0, 2), 0);
        wait_idle("t5");
        m_rx = 8;

        // abort in run 1 of 4, with an ignored start while busy
        m_lat = 100;
        base = ena_total;
        run_cmd(4, 3, 0, mk(0, 1, 100, 2, -1, 0, 2), 0);
        repeat (20) @(negedge clk);
        repeat_i = 8'd1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; repeat_i = 8'd4;
        n = 0;
        while (ena_total < base + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_second_ena", ena_total >= base + 2, 1);
        repeat (30) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        wait_idle("t6");

        // repeat 0 -> one run; rdy lands on the watchdog limit; abort with start ignored
        m_lat = 80;
        run_cmd(0, 0, 80, mk(0, 1, 80, 1, 0, 82, 0), 1);
        wait_idle("t7");

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
